// File: rtl/psl_cmd_arbiter_if.sv
// Command issue / response bundle between the three command sources, the
// arbiter and the PSL command/response ports.
interface psl_cmd_arbiter_if;
   localparam int unsigned COM_W  = 13;
   localparam int unsigned ADDR_W = 64;
   localparam int unsigned SIZE_W = 12;
   localparam int unsigned TAG_W  = 8;
   localparam int unsigned RSP_W  = 8;
   localparam int unsigned CNT_W  = 3;

   logic              misc_req;
   logic [COM_W-1:0]  misc_com;
   logic [ADDR_W-1:0] misc_addr;
   logic [SIZE_W-1:0] misc_size;
   logic              misc_ready;
   logic              misc_done;
   logic              misc_ok;

   logic              read_req;
   logic [COM_W-1:0]  read_com;
   logic [ADDR_W-1:0] read_addr;
   logic [SIZE_W-1:0] read_size;
   logic              read_ready;
   logic              read_done;
   logic              read_ok;

   logic              write_req;
   logic [COM_W-1:0]  write_com;
   logic [ADDR_W-1:0] write_addr;
   logic [SIZE_W-1:0] write_size;
   logic              write_ready;
   logic              write_done;
   logic              write_ok;

   logic              ah_cvalid;
   logic [COM_W-1:0]  ah_com;
   logic [TAG_W-1:0]  ah_ctag;
   logic [ADDR_W-1:0] ah_cea;
   logic [SIZE_W-1:0] ah_csize;

   logic              ha_rvalid;
   logic [TAG_W-1:0]  ha_rtag;
   logic [RSP_W-1:0]  ha_response;

   logic              tag_err;
   logic [CNT_W-1:0]  outstanding;

   // Arbiter side
   modport slave (
      input  misc_req, misc_com, misc_addr, misc_size,
      output misc_ready, misc_done, misc_ok,
      input  read_req, read_com, read_addr, read_size,
      output read_ready, read_done, read_ok,
      input  write_req, write_com, write_addr, write_size,
      output write_ready, write_done, write_ok,
      output ah_cvalid, ah_com, ah_ctag, ah_cea, ah_csize,
      input  ha_rvalid, ha_rtag, ha_response,
      output tag_err, outstanding
   );

   // Sources and PSL side
   modport master (
      output misc_req, misc_com, misc_addr, misc_size,
      input  misc_ready, misc_done, misc_ok,
      output read_req, read_com, read_addr, read_size,
      input  read_ready, read_done, read_ok,
      output write_req, write_com, write_addr, write_size,
      input  write_ready, write_done, write_ok,
      input  ah_cvalid, ah_com, ah_ctag, ah_cea, ah_csize,
      output ha_rvalid, ha_rtag, ha_response,
      input  tag_err, outstanding
   );
endinterface

// File: rtl/psl_cmd_arbiter.sv
// Round-robin sharing of the PSL command port between misc/read/write sources,
// with a small tag pool and per-tag owner routing of responses.
module psl_cmd_arbiter #(
   parameter int unsigned NTAGS = 4
) (
   input  logic              ha_pclock,
   input  logic              reset_n,
   psl_cmd_arbiter_if.slave  bus
);
   localparam int unsigned NSRC   = 3;
   localparam int unsigned SRC_W  = 2;
   localparam int unsigned TAG_W  = 2;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned COM_W  = 13;
   localparam int unsigned ADDR_W = 64;
   localparam int unsigned SIZE_W = 12;
   localparam int unsigned RTAG_W = 8;

   localparam logic [SRC_W-1:0] SRC_MISC  = 2'd0;
   localparam logic [SRC_W-1:0] SRC_READ  = 2'd1;
   localparam logic [SRC_W-1:0] SRC_WRITE = 2'd2;

   logic [NSRC-1:0]   req;
   logic [NSRC-1:0]   req_sh;
   logic [NSRC-1:0]   ready;
   logic              free_avail;
   logic              win_vld;
   logic [SRC_W-1:0]  win;
   logic [2:0]        cand;
   logic              xfer;
   logic [TAG_W-1:0]  alloc_tag;
   logic              alloc_fnd;
   logic [COM_W-1:0]  win_com;
   logic [ADDR_W-1:0] win_addr;
   logic [SIZE_W-1:0] win_size;
   logic [TAG_W-1:0]  rsp_tag;
   logic              rsp_hit;
   logic              rsp_err;

   logic [NTAGS-1:0]  busy_q, busy_d;
   logic [SRC_W-1:0]  owner_q [NTAGS];
   logic [SRC_W-1:0]  owner_d [NTAGS];
   logic [SRC_W-1:0]  last_q, last_d;
   logic              cvalid_q, cvalid_d;
   logic [COM_W-1:0]  com_q, com_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [ADDR_W-1:0] cea_q, cea_d;
   logic [SIZE_W-1:0] csize_q, csize_d;
   logic [NSRC-1:0]   done_q, done_d;
   logic [NSRC-1:0]   ok_q, ok_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  out_q, out_d;

   assign req = {bus.write_req, bus.read_req, bus.misc_req};

   // Round-robin winner, searching from the source after the last grant
   always_comb begin
      free_avail = ~&busy_q;
      win_vld    = 1'b0;
      win        = last_q;
      cand       = '0;
      req_sh     = '0;
      for (int k = 1; k <= int'(NSRC); k++) begin
         cand = {1'b0, last_q} + 3'(k);
         if (cand >= 3'(NSRC)) begin
            cand = cand - 3'(NSRC);
         end
         req_sh = req >> cand;
         if (!win_vld && req_sh[0]) begin
            win_vld = 1'b1;
            win     = cand[SRC_W-1:0];
         end
      end
      xfer  = win_vld & free_avail & reset_n;
      ready = xfer ? (NSRC'(1) << win) : '0;
   end

   // Lowest-numbered free tag, from start-of-cycle busy bits
   always_comb begin
      alloc_tag = '0;
      alloc_fnd = 1'b0;
      for (int i = 0; i < int'(NTAGS); i++) begin
         if (!busy_q[i] && !alloc_fnd) begin
            alloc_tag = TAG_W'(i);
            alloc_fnd = 1'b1;
         end
      end
   end

   always_comb begin
      win_com  = bus.misc_com;
      win_addr = bus.misc_addr;
      win_size = bus.misc_size;
      case (win)
         SRC_READ: begin
            win_com  = bus.read_com;
            win_addr = bus.read_addr;
            win_size = bus.read_size;
         end
         SRC_WRITE: begin
            win_com  = bus.write_com;
            win_addr = bus.write_addr;
            win_size = bus.write_size;
         end
         default: ;
      endcase
   end

   assign rsp_tag = bus.ha_rtag[TAG_W-1:0];
   assign rsp_hit = bus.ha_rvalid && (bus.ha_rtag[RTAG_W-1:TAG_W] == '0) && busy_q[rsp_tag];
   assign rsp_err = bus.ha_rvalid && !rsp_hit;

   // Allocation and freeing always touch different tags, so both apply
   always_comb begin
      busy_d   = busy_q;
      owner_d  = owner_q;
      last_d   = last_q;
      cvalid_d = xfer;
      com_d    = com_q;
      tag_d    = tag_q;
      cea_d    = cea_q;
      csize_d  = csize_q;
      done_d   = '0;
      ok_d     = '0;
      err_d    = err_q | rsp_err;
      out_d    = '0;

      if (rsp_hit) begin
         busy_d[rsp_tag] = 1'b0;
         done_d          = NSRC'(1) << owner_q[rsp_tag];
         ok_d            = (bus.ha_response == '0) ? done_d : '0;
      end

      if (xfer) begin
         busy_d[alloc_tag]  = 1'b1;
         owner_d[alloc_tag] = win;
         last_d             = win;
         com_d              = win_com;
         tag_d              = alloc_tag;
         cea_d              = win_addr;
         csize_d            = win_size;
      end

      for (int i = 0; i < int'(NTAGS); i++) begin
         out_d = out_d + CNT_W'(busy_d[i]);
      end
   end

   always_ff @(posedge ha_pclock) begin
      if (!reset_n) begin
         busy_q   <= '0;
         for (int i = 0; i < int'(NTAGS); i++) begin
            owner_q[i] <= SRC_MISC;
         end
         last_q   <= SRC_WRITE;
         cvalid_q <= 1'b0;
         com_q    <= '0;
         tag_q    <= '0;
         cea_q    <= '0;
         csize_q  <= '0;
         done_q   <= '0;
         ok_q     <= '0;
         err_q    <= 1'b0;
         out_q    <= '0;
      end else begin
         busy_q   <= busy_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         cvalid_q <= cvalid_d;
         com_q    <= com_d;
         tag_q    <= tag_d;
         cea_q    <= cea_d;
         csize_q  <= csize_d;
         done_q   <= done_d;
         ok_q     <= ok_d;
         err_q    <= err_d;
         out_q    <= out_d;
      end
   end

   assign bus.misc_ready  = ready[0];
   assign bus.read_ready  = ready[1];
   assign bus.write_ready = ready[2];
   assign bus.misc_done   = done_q[0];
   assign bus.read_done   = done_q[1];
   assign bus.write_done  = done_q[2];
   assign bus.misc_ok     = ok_q[0];
   assign bus.read_ok     = ok_q[1];
   assign bus.write_ok    = ok_q[2];
   assign bus.ah_cvalid   = cvalid_q;
   assign bus.ah_com      = com_q;
   assign bus.ah_ctag     = RTAG_W'(tag_q);
   assign bus.ah_cea      = cea_q;
   assign bus.ah_csize    = csize_q;
   assign bus.tag_err     = err_q;
   assign bus.outstanding = out_q;
endmodule
